x_alp_sim_exit_ctrl: RTL and testbench



---
 rtl/x_alp_sim_exit_pkg.sv | 22 ++
 rtl/x_alp_sim_exit_arb.sv | 28 ++
 rtl/x_alp_sim_exit_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_x_alp_sim_exit_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/x_alp_sim_exit_pkg.sv
// Shared types and helpers for the x_alp simulation-exit controller.
package x_alp_sim_exit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sim_exit_state_e;

    // Write-port payload layout: {code[30:0], done}.
    typedef struct packed {
        logic [30:0] code;
        logic        done;
    } sim_exit_report_t;

    localparam logic [31:0] TIMEOUT_CODE_DEFAULT = 32'hDEAD;

    function automatic int unsigned hart_id_w(input int unsigned num_harts);
        return (num_harts <= 1) ? 1 : $clog2(num_harts);
    endfunction

endpackage

// File: rtl/x_alp_sim_exit_arb.sv
// Picks the lowest-index hart holding a non-zero exit code (purely combinational).
module x_alp_sim_exit_arb
    import x_alp_sim_exit_pkg::*;
#(
    parameter int unsigned NUM_HARTS = 4,
    localparam int unsigned HartIdW = hart_id_w(NUM_HARTS)
) (
    input  logic [NUM_HARTS-1:0][30:0] codes_i,
    output logic                       found_o,
    output logic [30:0]                code_o,
    output logic [HartIdW-1:0]         hart_o
);

    // Scan downwards so the lowest matching index is written last.
    always_comb begin
        found_o = 1'b0;
        code_o  = '0;
        hart_o  = '0;
        for (int h = int'(NUM_HARTS) - 1; h >= 0; h--) begin
            if (codes_i[h] != '0) begin
                found_o = 1'b1;
                code_o  = codes_i[h];
                hart_o  = HartIdW'(h);
            end
        end
    end

endmodule

// File: rtl/x_alp_sim_exit_ctrl.sv
// Simulation-exit controller: aggregates per-hart exit reports into exit_valid/exit_value.
// Optional inactivity watchdog enabled by defining XALP_SIM_EXIT_TIMEOUT_EN.
module x_alp_sim_exit_ctrl
    import x_alp_sim_exit_pkg::*;
#(
    parameter int unsigned  NUM_HARTS      = 4,
    parameter bit           FAIL_FAST      = 1'b0,
    parameter int unsigned  TIMEOUT_CYCLES = 32'd1_000_000,
    parameter logic [31:0]  TIMEOUT_CODE   = TIMEOUT_CODE_DEFAULT,
    localparam int unsigned HartIdW        = hart_id_w(NUM_HARTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [HartIdW-1:0]   wr_hart_i,
    input  logic [31:0]          wr_data_i,
    output logic [NUM_HARTS-1:0] pending_o,
    output logic                 exit_valid_o,
    output logic [31:0]          exit_value_o,
    output logic [HartIdW-1:0]   exit_hart_o,
    output logic                 timeout_o,
    output logic                 err_o
);

    sim_exit_state_e            state_q, state_d;
    logic                       ready_q, ready_d;
    logic [NUM_HARTS-1:0]       pending_q, pending_d, pending_acc;
    logic [NUM_HARTS-1:0][30:0] codes_q, codes_d, codes_acc;
    logic                       exit_valid_q, exit_valid_d;
    logic [31:0]                exit_value_q, exit_value_d;
    logic [HartIdW-1:0]         exit_hart_q, exit_hart_d;
    logic                       err_q, err_d;

    sim_exit_report_t   report;
    logic               xfer, in_range, go_idle, accept, ff_hit, all_done;
    logic               arb_found;
    logic [30:0]        arb_code;
    logic [HartIdW-1:0] arb_hart;

    assign report   = sim_exit_report_t'(wr_data_i);
    assign xfer     = wr_valid_i & ready_q;
    assign in_range = 32'(wr_hart_i) < NUM_HARTS;
    assign go_idle  = (state_q == RUN) & ~enable_i;
    assign accept   = xfer & ~go_idle & report.done & in_range & pending_q[wr_hart_i];
    assign ff_hit   = FAIL_FAST & accept & (report.code != '0);
    assign all_done = accept & (pending_acc == '0);

    // Code/pending state as it stands after this cycle's report is absorbed.
    always_comb begin
        codes_acc   = codes_q;
        pending_acc = pending_q;
        if (accept) begin
            codes_acc[wr_hart_i]   = report.code;
            pending_acc[wr_hart_i] = 1'b0;
        end
    end

    x_alp_sim_exit_arb #(
        .NUM_HARTS(NUM_HARTS)
    ) u_arb (
        .codes_i(codes_acc),
        .found_o(arb_found),
        .code_o (arb_code),
        .hart_o (arb_hart)
    );

`ifdef XALP_SIM_EXIT_TIMEOUT_EN
    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q;
    logic            expire;

    // Any transfer reloads the counter, so a report always beats expiry.
    assign expire = ready_q & enable_i & ~xfer & (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == RUN) begin
            cnt_d = (go_idle || xfer) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (go_idle) begin
                timeout_q <= 1'b0;
            end else if (expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_CODE};
    assign timeout_o  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        pending_d    = pending_q;
        codes_d      = codes_q;
        exit_valid_d = exit_valid_q;
        exit_value_d = exit_value_q;
        exit_hart_d  = exit_hart_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                if (go_idle) begin
                    state_d      = IDLE;
                    ready_d      = 1'b0;
                    pending_d    = '1;
                    codes_d      = '0;
                    exit_valid_d = 1'b0;
                    exit_value_d = 32'd1;
                    exit_hart_d  = '0;
                end else begin
                    pending_d = pending_acc;
                    codes_d   = codes_acc;
                    if (xfer && (!in_range || (report.done && !pending_q[wr_hart_i]))) begin
                        err_d = 1'b1;
                    end
                    if (ff_hit) begin
                        state_d      = DONE;
                        ready_d      = 1'b0;
                        exit_valid_d = 1'b1;
                        exit_value_d = {1'b0, report.code};
                        exit_hart_d  = wr_hart_i;
                    end else if (all_done) begin
                        state_d      = DONE;
                        ready_d      = 1'b0;
                        exit_valid_d = 1'b1;
                        exit_value_d = arb_found ? {1'b0, arb_code} : 32'd0;
                        exit_hart_d  = arb_hart;
                    end
`ifdef XALP_SIM_EXIT_TIMEOUT_EN
                    else if (expire) begin
                        state_d      = DONE;
                        ready_d      = 1'b0;
                        exit_valid_d = 1'b1;
                        exit_value_d = TIMEOUT_CODE;
                        exit_hart_d  = '0;
                    end
`endif
                end
            end
            DONE: ;
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            pending_q    <= '1;
            codes_q      <= '0;
            exit_valid_q <= 1'b0;
            exit_value_q <= 32'd1;
            exit_hart_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            pending_q    <= pending_d;
            codes_q      <= codes_d;
            exit_valid_q <= exit_valid_d;
            exit_value_q <= exit_value_d;
            exit_hart_q  <= exit_hart_d;
            err_q        <= err_d;
        end
    end

    assign wr_ready_o   = ready_q;
    assign pending_o    = pending_q;
    assign exit_valid_o = exit_valid_q;
    assign exit_value_o = exit_value_q;
    assign exit_hart_o  = exit_hart_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_x_alp_sim_exit_ctrl.sv
// Directed bench: instance A (4 harts, no fail-fast) and B (5 harts, fail-fast) share stimulus.
module tb_x_alp_sim_exit_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr_valid = 1'b0;
    logic [2:0]  wr_hart = '0;
    logic [31:0] wr_data = '0;

    logic        ready_a, valid_a, tmo_a, err_a;
    logic [3:0]  pending_a;
    logic [31:0] value_a;
    logic [1:0]  hart_a;

    logic        ready_b, valid_b, tmo_b, err_b;
    logic [4:0]  pending_b;
    logic [31:0] value_b;
    logic [2:0]  hart_b;

    int checks = 0;
    int errors = 0;

    x_alp_sim_exit_ctrl #(
        .NUM_HARTS     (4),
        .FAIL_FAST     (1'b0),
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_CODE  (32'hDEAD)
    ) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (ready_a),
        .wr_hart_i   (wr_hart[1:0]),
        .wr_data_i   (wr_data),
        .pending_o   (pending_a),
        .exit_valid_o(valid_a),
        .exit_value_o(value_a),
        .exit_hart_o (hart_a),
        .timeout_o   (tmo_a),
        .err_o       (err_a)
    );

    x_alp_sim_exit_ctrl #(
        .NUM_HARTS     (5),
        .FAIL_FAST     (1'b1),
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_CODE  (32'hDEAD)
    ) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (ready_b),
        .wr_hart_i   (wr_hart),
        .wr_data_i   (wr_data),
        .pending_o   (pending_b),
        .exit_valid_o(valid_b),
        .exit_value_o(value_b),
        .exit_hart_o (hart_b),
        .timeout_o   (tmo_b),
        .err_o       (err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] h, input logic [30:0] code, input logic done);
        wr_valid = 1'b1;
        wr_hart  = h;
        wr_data  = {code, done};
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_data  = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        wr_valid = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic start_run();
        do_reset();
        enable = 1'b1;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL bench_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_pending", 32'(pending_a), 32'hF);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_value", value_a, 32'd1);
        check("rst_hart", 32'(hart_a), 32'd0);
        check("rst_timeout", 32'(tmo_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);

        // 1: all zero codes
        enable = 1'b1;
        step(1);
        check("t1_ready_run", 32'(ready_a), 32'd1);
        write(3'd0, 31'd0, 1'b1);
        write(3'd1, 31'd0, 1'b1);
        write(3'd2, 31'd0, 1'b1);
        check("t1_pending_mid", 32'(pending_a), 32'h8);
        check("t1_valid_mid", 32'(valid_a), 32'd0);
        check("t1_value_mid", value_a, 32'd1);
        write(3'd3, 31'd0, 1'b1);
        check("t1_valid", 32'(valid_a), 32'd1);
        check("t1_value", value_a, 32'd0);
        check("t1_pending", 32'(pending_a), 32'h0);
        check("t1_hart", 32'(hart_a), 32'd0);
        check("t1_ready_done", 32'(ready_a), 32'd0);

        // 2: lowest non-zero code wins at completion
        start_run();
        write(3'd0, 31'd0, 1'b1);
        write(3'd1, 31'd5, 1'b1);
        write(3'd2, 31'd3, 1'b1);
        check("t2_valid_mid", 32'(valid_a), 32'd0);
        write(3'd3, 31'd0, 1'b1);
        check("t2_valid", 32'(valid_a), 32'd1);
        check("t2_value", value_a, 32'd5);
        check("t2_hart", 32'(hart_a), 32'd1);

        // 3: fail-fast
        start_run();
        write(3'd2, 31'd7, 1'b1);
        check("t3_valid", 32'(valid_b), 32'd1);
        check("t3_value", value_b, 32'd7);
        check("t3_hart", 32'(hart_b), 32'd2);
        check("t3_ready", 32'(ready_b), 32'd0);
        check("t3_pending", 32'(pending_b), 32'h1B);
        enable = 1'b0;
        step(1);
        check("t3_done_sticky", 32'(valid_b), 32'd1);
        check("t3_done_ready", 32'(ready_b), 32'd0);

        // 4: duplicate report and out-of-range hart
        start_run();
        write(3'd1, 31'd0, 1'b1);
        check("t4_pending_first", 32'(pending_b), 32'h1D);
        check("t4_err_first", 32'(err_b), 32'd0);
        write(3'd1, 31'd9, 1'b1);
        check("t4_pending_dup", 32'(pending_b), 32'h1D);
        check("t4_err_dup", 32'(err_b), 32'd1);
        check("t4_valid_dup", 32'(valid_b), 32'd0);
        write(3'd0, 31'd0, 1'b1);
        write(3'd2, 31'd0, 1'b1);
        write(3'd3, 31'd0, 1'b1);
        write(3'd4, 31'd0, 1'b1);
        check("t4_valid", 32'(valid_b), 32'd1);
        check("t4_value_kept", value_b, 32'd0);
        start_run();
        write(3'd5, 31'd0, 1'b1);
        check("t4_err_range", 32'(err_b), 32'd1);
        check("t4_pending_range", 32'(pending_b), 32'h1F);
        enable = 1'b0;
        step(1);
        check("t4_idle_err_kept", 32'(err_b), 32'd1);
        check("t4_idle_ready", 32'(ready_b), 32'd0);

        // 5: watchdog
`ifdef XALP_SIM_EXIT_TIMEOUT_EN
        start_run();
        step(9);
        write(3'd0, 31'd0, 1'b0);
        check("t5_hb_pending", 32'(pending_a), 32'hF);
        step(15);
        check("t5_tmo_before", 32'(tmo_a), 32'd0);
        check("t5_valid_before", 32'(valid_a), 32'd0);
        step(1);
        check("t5_tmo", 32'(tmo_a), 32'd1);
        check("t5_valid", 32'(valid_a), 32'd1);
        check("t5_value", value_a, 32'hDEAD);
        check("t5_hart", 32'(hart_a), 32'd0);
        start_run();
        write(3'd0, 31'd0, 1'b1);
        write(3'd1, 31'd0, 1'b1);
        write(3'd2, 31'd0, 1'b1);
        step(15);
        write(3'd3, 31'd0, 1'b1);
        check("t5_race_tmo", 32'(tmo_a), 32'd0);
        check("t5_race_valid", 32'(valid_a), 32'd1);
        check("t5_race_value", value_a, 32'd0);
`endif

        // 6: asynchronous reset mid-run, then a fresh run
        start_run();
        write(3'd0, 31'd0, 1'b1);
        write(3'd1, 31'd2, 1'b1);
        check("t6_pending_mid", 32'(pending_a), 32'hC);
        enable = 1'b0;
        rst    = 1'b1;
        #2;
        check("t6_async_pending", 32'(pending_a), 32'hF);
        check("t6_async_ready", 32'(ready_a), 32'd0);
        check("t6_async_valid", 32'(valid_a), 32'd0);
        check("t6_async_value", value_a, 32'd1);
        rst    = 1'b0;
        enable = 1'b1;
        step(1);
        write(3'd0, 31'd0, 1'b1);
        write(3'd1, 31'd0, 1'b1);
        write(3'd2, 31'd0, 1'b1);
        write(3'd3, 31'd4, 1'b1);
        check("t6_valid", 32'(valid_a), 32'd1);
        check("t6_value", value_a, 32'd4);
        check("t6_hart", 32'(hart_a), 32'd3);
        check("t6_err", 32'(err_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
